operand_recovery_serial: RTL and testbench

Bit-serial inverse of the operand adder: given a sum `result_in` and one addend `operand_1_in`, it recovers the other addend `operand_2_out = result_in - operand_1_in`. It also flags sums that no pair of WIDTH-bit operands could have produced. It sits downstream of the adder on the same operand/result path and uses valid/ready handshakes on both sides. It processes one bit per clock, LSB first, so the subtractor hardware is a single-bit cell.

---
 rtl/operand_recovery_serial_pkg.sv | 15 +
 rtl/operand_recovery_serial_full_subtractor_bit.sv | 13 +
 rtl/operand_recovery_serial.sv | 79 +++++++
 tb/tb_operand_recovery_serial.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/operand_recovery_serial_pkg.sv
// Shared types and sizing helper for the bit-serial operand recovery block.
package operand_recovery_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter must be able to hold WIDTH (the terminal bit index).
   function automatic int cnt_width(input int w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/operand_recovery_serial_full_subtractor_bit.sv
// One-bit full subtractor cell: a - b - borrow_in.
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic diff,
   output logic borrow_out
);

   assign diff       = a ^ b ^ borrow_in;
   assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/operand_recovery_serial.sv
// Bit-serial recovery of operand_2 = result - operand_1, LSB first, with an
// inconsistency flag for sums no pair of WIDTH-bit operands can produce.
module operand_recovery_serial
   import operand_recovery_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   result_in,
   input  logic [WIDTH-1:0] operand_1_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] operand_2_out,
   output logic             mismatch
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH);

   state_t          state_q;
   logic [WIDTH:0]  a_q, b_q, diff_q;
   logic            borrow_q;
   logic [CW-1:0]   cnt_q;
   logic            d_bit, borrow_nxt;

   full_subtractor_bit u_fsb (
      .a          (a_q[0]),
      .b          (b_q[0]),
      .borrow_in  (borrow_q),
      .diff       (d_bit),
      .borrow_out (borrow_nxt)
   );

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = (state_q == DONE);
   assign operand_2_out = diff_q[WIDTH-1:0];
   // Negative result (final borrow) or a result needing WIDTH+1 bits.
   assign mismatch      = borrow_q | diff_q[WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= result_in;
                  b_q      <= {1'b0, operand_1_in};
                  diff_q   <= '0;
                  borrow_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= SHIFT;
               end
            end
            SHIFT: begin
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               diff_q   <= {d_bit, diff_q[WIDTH:1]};
               borrow_q <= borrow_nxt;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == LAST) state_q <= DONE;
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_recovery_serial.sv
// Directed bench for operand_recovery_serial (WIDTH=8).
module tb_operand_recovery_serial;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH:0]   result_in = '0;
   logic [WIDTH-1:0] operand_1_in = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] operand_2_out;
   logic             mismatch;

   int errors = 0;
   int checks = 0;

   operand_recovery_serial #(.WIDTH(WIDTH)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .result_in     (result_in),
      .operand_1_in  (operand_1_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .operand_2_out (operand_2_out),
      .mismatch      (mismatch)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start a job, wait for out_valid (checking the latency), check the
   // outputs, stall `stall` cycles, then take the output handshake.
   task automatic do_job(input string tag, input logic [8:0] res, input logic [7:0] op1,
                         input logic [7:0] exp2, input logic expmm, input int stall);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      chk({tag, "_in_ready"}, in_ready, 1);
      result_in    = res;
      operand_1_in = op1;
      in_valid     = 1'b1;
      step();
      in_valid     = 1'b0;
      result_in    = $urandom;
      operand_1_in = $urandom;
      n = 0;
      while (!out_valid && n < 30) begin step(); n++; end
      chk({tag, "_latency"}, n, 9);
      chk({tag, "_op2"}, operand_2_out, exp2);
      chk({tag, "_mismatch"}, mismatch, expmm);
      for (int i = 0; i < stall; i++) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_ready_after"}, in_ready, 1);
   endtask

   initial begin
      logic [7:0] op1, op2, hold2;
      logic       holdmm;
      int         n;

      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_op2", operand_2_out, 0);
      chk("rst_mismatch", mismatch, 0);
      step();
      reset_n = 1'b1;
      step();

      do_job("basic", 9'h12C, 8'hC8, 8'h64, 1'b0, 0);
      do_job("max", 9'h1FE, 8'hFF, 8'hFF, 1'b0, 0);
      do_job("zero", 9'h000, 8'h00, 8'h00, 1'b0, 0);
      do_job("borrow", 9'h005, 8'h0A, 8'hFB, 1'b1, 0);
      do_job("bit8", 9'h1FF, 8'h00, 8'hFF, 1'b1, 0);

      // Backpressure with an ignored in_valid while in DONE.
      result_in = 9'h12C; operand_1_in = 8'hC8; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 30) begin step(); n++; end
      chk("bp_latency", n, 9);
      hold2 = operand_2_out; holdmm = mismatch;
      chk("bp_op2", hold2, 8'h64);
      result_in = 9'h005; operand_1_in = 8'h0A; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_op2_stable", operand_2_out, 8'h64);
         chk("bp_mm_stable", mismatch, holdmm);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_ready", in_ready, 1);
      for (int i = 0; i < 12; i++) step();
      chk("bp_no_ghost_job", out_valid, 0);

      // Reset four cycles into SHIFT.
      result_in = 9'h1FF; operand_1_in = 8'h00; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("mid_busy", in_ready, 0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_op2", operand_2_out, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_mm", mismatch, 0);
      #3;
      reset_n = 1'b1;
      step();
      do_job("after_rst", 9'h12C, 8'hC8, 8'h64, 1'b0, 0);

      // Streaming legal pairs with random output stalls.
      for (int j = 0; j < 50; j++) begin
         op1 = 8'($urandom_range(0, 255));
         op2 = 8'($urandom_range(0, 255));
         do_job($sformatf("stream%0d", j), {1'b0, op1} + {1'b0, op2}, op1, op2, 1'b0,
                $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
